port_injector: RTL and testbench

PORT_INJECTOR -- requirements
Module: port_injector

---
 rtl/port_injector.sv | 119 +++++++++++
 tb/tb_port_injector.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/port_injector.sv
// Bus-loaded byte injector: four independent FIFOs, one for each switch input port.
// Each FIFO is filled over Avalon-MM and drained through a valid/ready handshake.
module port_injector #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       chipselect,
  input  logic       write,
  input  logic       read,
  input  logic [2:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic [7:0] data0,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [7:0] data3,
  output logic       en0,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  input  logic       ready0,
  input  logic       ready1,
  input  logic       ready2,
  input  logic       ready3
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

  logic [7:0]    mem    [4][DEPTH];
  logic [AW-1:0] rd_ptr [4];
  logic [AW-1:0] wr_ptr [4];
  logic [AW:0]   level  [4];
  logic [7:0]    head   [4];

  logic [3:0] mask, ovf;
  logic [3:0] rdy, en, empty, full, push, pop, flush, ovf_set, ovf_clr;
  logic       wr_en, rd_en;
  logic [7:0] rd_mux;

  assign wr_en = chipselect && write;
  assign rd_en = chipselect && read;

  always_comb begin
    rdy = {ready3, ready2, ready1, ready0};
    for (int i = 0; i < 4; i++) begin
      empty[i]   = (level[i] == '0);
      full[i]    = (level[i] == LVL_FULL);
      en[i]      = mask[i] && !empty[i];
      pop[i]     = en[i] && rdy[i];
      push[i]    = wr_en && (address == i[2:0]) && !full[i];
      // A full FIFO refuses the byte even if the same edge pops it.
      ovf_set[i] = wr_en && (address == i[2:0]) && full[i];
      ovf_clr[i] = wr_en && (address == 3'd5) && writedata[i];
      flush[i]   = wr_en && (address == 3'd6) && writedata[i];
      // Gate on empty so reset and flushed FIFOs never expose stale storage.
      head[i]    = empty[i] ? 8'h00 : mem[i][rd_ptr[i]];
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    case (address)
      3'd0, 3'd1, 3'd2, 3'd3: rd_mux = 8'(level[address[1:0]]);
      3'd4:                   rd_mux = {4'b0000, mask};
      3'd5:                   rd_mux = {empty, ovf};
      default:                rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= writedata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        level[i]  <= '0;
      end
      mask     <= 4'h0;
      ovf      <= 4'h0;
      readdata <= 8'h00;
    end else begin
      if (wr_en && (address == 3'd4)) mask <= writedata[3:0];
      ovf <= (ovf & ~ovf_clr) | ovf_set;
      for (int i = 0; i < 4; i++) begin
        if (flush[i]) begin
          rd_ptr[i] <= '0;
          wr_ptr[i] <= '0;
          level[i]  <= '0;
        end else begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
          case ({push[i], pop[i]})
            2'b10:   level[i] <= level[i] + 1'b1;
            2'b01:   level[i] <= level[i] - 1'b1;
            default: level[i] <= level[i];
          endcase
        end
      end
      if (rd_en) readdata <= rd_mux;
    end
  end

  assign data0 = head[0];
  assign data1 = head[1];
  assign data2 = head[2];
  assign data3 = head[3];
  assign en0   = en[0];
  assign en1   = en[1];
  assign en2   = en[2];
  assign en3   = en[3];

endmodule

// File: tb/tb_port_injector.sv
// Directed bench for port_injector (DEPTH = 16) with hand-computed expectations.
module tb_port_injector;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       chipselect, write, read;
  logic [2:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic [7:0] data0, data1, data2, data3;
  logic       en0, en1, en2, en3;
  logic       ready0, ready1, ready2, ready3;

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] rd;

  port_injector #(.DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .en0(en0), .en1(en1), .en2(en2), .en3(en3),
    .ready0(ready0), .ready1(ready1), .ready2(ready2), .ready3(ready3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  initial begin
    reset_n = 1'b0;
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 3'd0; writedata = 8'h00;
    ready0 = 1'b0; ready1 = 1'b0; ready2 = 1'b0; ready3 = 1'b0;
    #3;
    check("reset_en", {28'h0, en3, en2, en1, en0}, 32'h0);
    check("reset_readdata", {24'h0, readdata}, 32'h0);
    check("reset_data", {data3, data2, data1, data0}, 32'h0);
    #9 reset_n = 1'b1;
    tick();

    // basic stream on port 0
    bus_write(3'd4, 8'h01);
    bus_write(3'd0, 8'h11);
    check("latency_en0", {31'h0, en0}, 32'h1);
    check("latency_data0", {24'h0, data0}, 32'h11);
    bus_write(3'd0, 8'h22);
    bus_write(3'd0, 8'h33);
    bus_read(3'd0, rd);
    check("basic_level3", {24'h0, rd}, 32'h3);
    ready0 = 1'b1;
    check("basic_b0", {23'h0, en0, data0}, {23'h0, 1'b1, 8'h11});
    tick();
    check("basic_b1", {23'h0, en0, data0}, {23'h0, 1'b1, 8'h22});
    tick();
    check("basic_b2", {23'h0, en0, data0}, {23'h0, 1'b1, 8'h33});
    tick();
    check("basic_en0_done", {31'h0, en0}, 32'h0);
    ready0 = 1'b0;
    bus_read(3'd0, rd);
    check("basic_level0", {24'h0, rd}, 32'h0);

    // backpressure on port 2
    bus_write(3'd2, 8'hA1);
    bus_write(3'd2, 8'hA2);
    check("bp_masked_en2", {31'h0, en2}, 32'h0);
    bus_write(3'd4, 8'h04);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold", {23'h0, en2, data2}, {23'h0, 1'b1, 8'hA1});
      tick();
    end
    bus_read(3'd2, rd);
    check("bp_level", {24'h0, rd}, 32'h2);
    ready2 = 1'b1;
    check("bp_drain0", {23'h0, en2, data2}, {23'h0, 1'b1, 8'hA1});
    tick();
    check("bp_drain1", {23'h0, en2, data2}, {23'h0, 1'b1, 8'hA2});
    tick();
    check("bp_empty", {31'h0, en2}, 32'h0);
    ready2 = 1'b0;

    // overflow on port 3
    bus_write(3'd4, 8'h00);
    for (int k = 0; k < 18; k++) bus_write(3'd3, 8'h30 + 8'(k));
    bus_read(3'd3, rd);
    check("ovf_level", {24'h0, rd}, 32'h10);
    bus_read(3'd5, rd);
    check("ovf_status_set", {24'h0, rd}, 32'h78);
    bus_write(3'd5, 8'h08);
    bus_read(3'd5, rd);
    check("ovf_status_clr", {24'h0, rd}, 32'h70);
    bus_write(3'd4, 8'h08);
    ready3 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("ovf_drain", {23'h0, en3, data3}, {23'h0, 1'b1, 8'h30 + 8'(k)});
      tick();
    end
    check("ovf_drained", {31'h0, en3}, 32'h0);
    ready3 = 1'b0;

    // full port 1 while streaming, then push+pop at DEPTH-1
    bus_write(3'd4, 8'h00);
    for (int k = 0; k < 16; k++) bus_write(3'd1, 8'h40 + 8'(k));
    bus_write(3'd4, 8'h02);
    ready1 = 1'b1;
    bus_write(3'd1, 8'hEE);
    bus_write(3'd1, 8'hEF);
    ready1 = 1'b0;
    bus_read(3'd1, rd);
    check("sim_level", {24'h0, rd}, 32'h0F);
    bus_read(3'd5, rd);
    check("sim_status", {24'h0, rd}, 32'hD2);
    ready1 = 1'b1;
    for (int k = 0; k < 14; k++) begin
      check("sim_drain", {23'h0, en1, data1}, {23'h0, 1'b1, 8'h42 + 8'(k)});
      tick();
    end
    check("sim_last", {23'h0, en1, data1}, {23'h0, 1'b1, 8'hEF});
    tick();
    check("sim_empty", {31'h0, en1}, 32'h0);
    ready1 = 1'b0;
    bus_write(3'd5, 8'h02);

    // streaming through port 0 across three pointer wraps
    bus_write(3'd4, 8'h01);
    ready0 = 1'b1;
    for (int k = 0; k < 48; k++) begin
      chipselect = 1'b1; write = 1'b1; address = 3'd0; writedata = 8'(k * 5 + 3);
      if (k > 0) check("wrap_stream", {23'h0, en0, data0}, {23'h0, 1'b1, 8'((k - 1) * 5 + 3)});
      tick();
    end
    chipselect = 1'b0; write = 1'b0;
    check("wrap_last", {23'h0, en0, data0}, {23'h0, 1'b1, 8'(47 * 5 + 3)});
    tick();
    check("wrap_empty", {31'h0, en0}, 32'h0);

    // flush while a pop is in flight
    ready0 = 1'b0;
    bus_write(3'd0, 8'h91);
    bus_write(3'd0, 8'h92);
    bus_write(3'd0, 8'h93);
    ready0 = 1'b1;
    bus_write(3'd6, 8'h01);
    check("flush_en0", {31'h0, en0}, 32'h0);
    ready0 = 1'b0;
    bus_read(3'd0, rd);
    check("flush_level", {24'h0, rd}, 32'h0);

    // address 7 writes are ignored; address 6 reads as zero
    bus_write(3'd7, 8'hFF);
    bus_read(3'd4, rd);
    check("addr7_mask", {24'h0, rd}, 32'h01);
    bus_read(3'd6, rd);
    check("addr6_read", {24'h0, rd}, 32'h0);

    // asynchronous reset with bytes on every port
    bus_write(3'd4, 8'h0F);
    bus_write(3'd0, 8'h51);
    bus_write(3'd1, 8'h52);
    bus_write(3'd2, 8'h53);
    bus_write(3'd3, 8'h54);
    check("pre_reset_en", {28'h0, en3, en2, en1, en0}, 32'hF);
    check("pre_reset_data", {data3, data2, data1, data0}, 32'h54535251);
    bus_read(3'd4, rd);
    check("pre_reset_mask", {24'h0, rd}, 32'h0F);
    #2 reset_n = 1'b0;
    #1;
    check("async_en", {28'h0, en3, en2, en1, en0}, 32'h0);
    check("async_readdata", {24'h0, readdata}, 32'h0);
    check("async_data", {data3, data2, data1, data0}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_reset_en", {28'h0, en3, en2, en1, en0}, 32'h0);
    for (int p = 0; p < 4; p++) begin
      bus_read(3'(p), rd);
      check("post_reset_level", {24'h0, rd}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
